// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

  // Next-PC source, listed in increasing priority order after Seq.
  typedef enum logic [2:0] {
    Seq,
    Br,
    Jmp,
    Ret,
    Jr
  } pc_src_e;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry. Over/underflow raise a sticky error. Entry storage is not
// reset; it is only observable once something has been pushed.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0]   CntOne = (PtrW+1)'(1);
  localparam logic [PtrW:0]   CntMax = (PtrW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];

  // sp_q points at the next free slot; the top entry sits just below it.
  logic [PtrW-1:0] sp_q, sp_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            we;
  logic [PtrW-1:0] waddr;
  logic [PtrW-1:0] top_idx;

  assign top_idx = sp_q - PtrOne;
  assign top     = mem[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntMax);
  assign err     = err_q;

  // Next-state for pointer, count and sticky error, plus the write port.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    we    = 1'b0;
    waddr = sp_q;
    if (pop && push) begin
      if (empty) begin
        // Failed pop, then an ordinary push into the empty stack.
        err_d = 1'b1;
        we    = 1'b1;
        sp_d  = sp_q + PtrOne;
        cnt_d = CntOne;
      end else begin
        // Pop then push collapses into replacing the top entry.
        we    = 1'b1;
        waddr = top_idx;
      end
    end else if (push) begin
      we   = 1'b1;
      sp_d = sp_q + PtrOne;
      if (full) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end else if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        sp_d  = top_idx;
        cnt_d = cnt_q - CntOne;
      end
    end
  end

  // Pointer, count and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry storage, deliberately without reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= din;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch, pseudo-direct jump, register jump and a
// return-address stack for predicted returns.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br,
  input  logic             br_ne,
  input  logic             zero,
  input  logic [WIDTH-1:0] br_off,
  input  logic             jmp,
  input  logic [WIDTH-7:0] jaddr,
  input  logic             call,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic             redirect,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redirect_q, redirect_d;
  pc_src_e          src;
  logic             br_taken;
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;

  assign pc       = pc_q;
  assign pc4      = pc_q + WIDTH'(PC_STEP);
  assign redirect = redirect_q;
  assign br_taken = br & (zero ^ br_ne);

  // A lone call is meaningless; jr pre-empts both push and pop.
  assign ras_push = ~stall & ~jr & jmp & call;
  assign ras_pop  = ~stall & ~jr & ret;

  // Priority source select and next-PC mux.
  always_comb begin
    src = Seq;
    if (jr) begin
      src = Jr;
    end else if (ret) begin
      src = Ret;
    end else if (jmp) begin
      src = Jmp;
    end else if (br_taken) begin
      src = Br;
    end

    pc_d = pc4;
    unique case (src)
      Jr:      pc_d = {jr_addr[WIDTH-1:2], 2'b00};
      Ret:     pc_d = ras_empty ? jr_addr : ras_top;
      Jmp:     pc_d = {pc4[WIDTH-1:WIDTH-4], jaddr, 2'b00};
      Br:      pc_d = pc4 + (br_off << 2);
      default: pc_d = pc4;
    endcase

    redirect_d = (src != Seq);
    if (stall) begin
      pc_d       = pc_q;
      redirect_d = 1'b0;
    end
  end

  // PC and redirect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .err   (ras_err)
  );

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC and address width in bits; legal range 16..32.
REQ-002 Parameter RAS_DEPTH, default 4: number of return-address-stack entries; power of two, at least 2.
REQ-003 Parameter RESET_VEC, default 0: PC value loaded on reset; word-aligned.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 stall  in  1  hold PC and RAS for this cycle.
REQ-007 br  in  1  conditional branch request.
REQ-008 br_ne  in  1  branch sense: 0 = taken when zero=1 (beq); 1 = taken when zero=0 (bne).
REQ-009 zero  in  1  ALU zero flag.
REQ-010 br_off  in  WIDTH  sign-extended word offset.
REQ-011 jmp  in  1  pseudo-direct jump request.
REQ-012 jaddr  in  WIDTH-6  jump word index.
REQ-013 call  in  1  push return address; valid only together with jmp (jal).
REQ-014 jr  in  1  register jump request.
REQ-015 jr_addr  in  WIDTH  register jump target.
REQ-016 ret  in  1  predicted return; pop the RAS.
REQ-017 pc  out  WIDTH  current PC, registered.
REQ-018 pc4  out  WIDTH  pc+4, combinational.
REQ-019 redirect  out  1  registered; high for one cycle after any non-sequential PC update.
REQ-020 ras_empty, ras_full  out  1 each  occupancy flags, combinational from the count.
REQ-021 ras_err  out  1  sticky; set on pop when empty or push when full; cleared only by reset.

Function
REQ-022 Next-PC priority: stall > jr > ret > jmp > taken br > sequential.
REQ-023 Sequential next PC: pc+4, computed modulo 2^WIDTH.
REQ-024 Taken-branch target: pc+4+(br_off<<2), modulo 2^WIDTH.
REQ-025 Branch taken condition: br & (zero ^ br_ne); an untaken br selects the sequential PC.
REQ-026 Jump target: {pc4[WIDTH-1:WIDTH-4], jaddr, 2'b00}.
REQ-027 jr target: jr_addr with bits [1:0] forced to 0.
REQ-028 ret with RAS non-empty: target is the top entry, and the entry is popped.
REQ-029 ret with RAS empty: target is jr_addr, ras_err is set, and the count stays 0.
REQ-030 call & jmp, when jmp is the winning source: push pc+4.
REQ-031 Push when full: overwrite the oldest entry circularly, count stays RAS_DEPTH, ras_err is set.
REQ-032 call without jmp: ignored, no push.
REQ-033 call & jmp & ret together: ret wins the PC; the RAS does a pop followed by a push, so top = pc+4 and count is unchanged.
REQ-034 stall=1: pc, RAS and count hold; redirect=0 next cycle; all other inputs ignored.
REQ-035 redirect is set when the selected source is jr, ret, jmp or a taken br, and stall=0.
REQ-036 Single-cycle latency: a request sampled at edge N is visible on pc after edge N.

Reset
REQ-037 rst=1 asynchronously forces pc=RESET_VEC, RAS count=0, stack pointer=0, redirect=0, ras_err=0.
REQ-038 RAS entry contents are not reset; they are unobservable while the count is 0.
REQ-039 Reset asserted mid-stall or mid-redirect: reset values take effect immediately.
REQ-040 After rst deasserts, the first rising edge with stall=0 loads RESET_VEC+4.

Structure
REQ-041 Shared package pc_pkg holds the next-PC source enum (SEQ, BR, JMP, RET, JR) and the PC_STEP=4 constant.
REQ-042 The RAS is a separate sub-module, ras_stack: parameters WIDTH and RAS_DEPTH; ports push, pop, din, top, empty, full, err.
REQ-043 Next-PC selection is a single combinational priority mux in pc_unit.

Verification
REQ-044 Reset, then 3 idle edges -> pc = 0, 4, 8, 12; redirect=0 throughout.
REQ-045 pc=0x100, br=1, br_ne=0, zero=1, br_off=-2 -> pc=0xFC, redirect=1; same stimulus with zero=0 -> pc=0x104, redirect=0.
REQ-046 pc=0x40000010, jmp=1, call=1, jaddr=0x10 -> pc=0x40000040, top=0x40000014; then ret=1 -> pc=0x40000014, ras_empty=1.
REQ-047 Five calls with RAS_DEPTH=4 -> ras_full=1, ras_err=1; four rets return the last four pushed addresses in LIFO order; a fifth ret -> pc=jr_addr.
REQ-048 stall=1 together with jr=1, jr_addr=0x203 -> pc unchanged; stall=0 on the next cycle -> pc=0x200, redirect=1.
REQ-049 rst asserted between clock edges during a redirect -> pc=RESET_VEC immediately; redirect and ras_err = 0.
